sprite_field: RTL and testbench
===============================

# sprite_field

Parametrised bouncing-sprite engine for the VGA path. Holds N square sprites with per-sprite half-size, colour, start position and direction. Advances every sprite once per frame through a sequential update FSM and loads sprite positions through a ready/valid port. Produces a registered, priority-resolved 1-bit-per-channel RGB pixel plus an overlap flag for the current VGA coordinate, replacing hand-instantiated per-square logic in the top level.

## Interface

Parameters:
- N, 3, number of sprites, 1..8
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- STEP, 1, pixels moved per axis per update; STEP < every half-size
- HALF, {10'd40,10'd80,10'd60}, packed N×10 half-sizes; sprite i at bits [10i+9:10i]; 2·half < SCREEN_H
- COLOUR, {3'b010,3'b001,3'b100}, packed N×3 {r,g,b} colours per sprite
- INIT_X, {10'd300,10'd400,10'd160}, packed N×10 reset centre x
- INIT_Y, {10'd320,10'd240,10'd120}, packed N×10 reset centre y
- INIT_DIR, {2'b10,2'b01,2'b11}, packed N×2 {xdir,ydir}; 1 = increasing

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pixclk  in  1  pixel-enable strobe; pixel path advances only when high
- animate  in  1  one-cycle new-frame pulse
- pause  in  1  when high, animate pulses are discarded
- x  in  10  current pixel column
- y  in  10  current pixel row
- valid  in  1  current pixel is in the visible area
- ld_valid  in  1  position load request
- ld_idx  in  3  sprite index to load
- ld_x  in  10  new centre x
- ld_y  in  10  new centre y
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- busy  out  1  update FSM is not IDLE
- r, g, b  out  1 each  pixel colour, registered
- hit  out  1  two or more sprites cover the pixel, registered

## Operation

- Per-sprite state: cx, cy (10 b), xdir, ydir. Reset values come from INIT_X, INIT_Y and INIT_DIR.
- FSM states are IDLE and UPDATE. IDLE→UPDATE happens when a start condition exists; idx resets to 0. UPDATE handles sprite idx each cycle and increments idx. When idx = N−1 it returns to IDLE.
- Start condition in IDLE: (animate && !pause) or pending.
- The pending flag is set by animate && !pause while in UPDATE, or by animate && !pause coinciding with an accepted load. It is cleared when UPDATE is entered. The flag is one deep; extra pulses are lost.
- Per-axis update, shown for x (y is the same with SCREEN_H). Calculations use 11-bit arithmetic.
  - xdir = 1: cand = cx + STEP. If cand + h ≥ SCREEN_W, then cx ← SCREEN_W−1−h and xdir ← 0. Otherwise cx ← cand.
  - xdir = 0: if cx < h + STEP, then cx ← h and xdir ← 1. Otherwise cx ← cx − STEP.
- Load handling:
  - ld_ready = (state == IDLE).
  - On accept, sprite ld_idx is written with ld_x and ld_y; its directions are unchanged.
  - ld_idx ≥ N is accepted and ignored.
  - A load wins over animate in the same cycle. That animate is converted to pending.
  - Loaded values are not clamped.
- Pixel path, evaluated on clk edges where pixclk = 1:
  - in_i = x > cx−h && x < cx+h && y > cy−h && y < cy+h. Comparisons are strict and signed 11-bit.
  - {r,g,b} ← COLOUR of the lowest i with in_i, or 0 if no sprite covers the pixel or valid = 0.
  - hit ← valid && (popcount(in) ≥ 2).
  - When pixclk = 0, the outputs hold.

## Timing

- Reset (asynchronous): r = g = b = 0, hit = 0, busy = 0, ld_ready = 1, state IDLE, pending = 0, sprites at their INIT values.
- Animate sampled at edge t: busy = 1 from t+1. Sprite i is written at edge t+1+i. busy = 0 and ld_ready = 1 after edge t+N.
- Load accepted at edge t: the new position is visible to the pixel path from edge t+1.
- Pixel latency: 1 pixclk-qualified clock from x/y/valid to r/g/b/hit.
- The pixel path reads live positions. Updates are expected during blanking (animate coincides with the start of vertical blanking).
- Reset asserted mid-UPDATE: partial positions are discarded and all sprites return to their INIT values.

## Test plan

- Reset, then one animate with defaults: after N+1 clocks sprite0 = (161,121), sprite1 = (399,241), sprite2 = (301,319). busy is high for exactly 3 cycles.
- Right-edge bounce: load sprite0 to (578,120), then animate three times. Sprite0 cx goes 579, 579 (xdir becomes 0), 578.
- Pixel priority: load sprite1 to (160,120), then drive x=160, y=120, valid=1, pixclk=1. Next cycle {r,g,b}=100 and hit=1. With x=100 (boundary excluded for sprite0, inside sprite1): {r,g,b}=001, hit=0.
- Blanking and pause: with valid=0, {r,g,b}=000 and hit=0. With pause=1, animate leaves all positions unchanged and busy stays 0.
- Handshake collisions:
  - animate during UPDATE → pending → second UPDATE starts right after IDLE; sprite0 advances by 2.
  - ld_valid during UPDATE is held off (ld_ready = 0) and accepted in the first IDLE cycle.
  - ld_idx = 7 changes nothing.
- Asynchronous reset asserted at the second UPDATE cycle: outputs clear immediately and sprite positions equal INIT_X/INIT_Y.

Source files
------------

// File: rtl/sprite_field_if.sv
// Bundle of pixel, load and status signals for sprite_field.
// Load port: a transfer happens on a clk edge where ld_valid && ld_ready. ld_valid and its payload must stay stable until then.
interface sprite_field_if #(
    parameter int N = 3
);
    logic            pixclk;
    logic            animate;
    logic            pause;
    logic [9:0]      x;
    logic [9:0]      y;
    logic            valid;
    logic            ld_valid;
    logic [2:0]      ld_idx;
    logic [9:0]      ld_x;
    logic [9:0]      ld_y;
    logic            ld_ready;
    logic            busy;
    logic            r;
    logic            g;
    logic            b;
    logic            hit;
    logic            dbg_state;
    logic [N*10-1:0] dbg_cx;
    logic [N*10-1:0] dbg_cy;

    modport master (
        output pixclk, animate, pause, x, y, valid, ld_valid, ld_idx, ld_x, ld_y,
        input  ld_ready, busy, r, g, b, hit, dbg_state, dbg_cx, dbg_cy
    );

    modport slave (
        input  pixclk, animate, pause, x, y, valid, ld_valid, ld_idx, ld_x, ld_y,
        output ld_ready, busy, r, g, b, hit, dbg_state, dbg_cx, dbg_cy
    );
endinterface

// File: rtl/sprite_field.sv
// Bouncing-sprite engine: N square sprites advanced one per cycle after each frame pulse,
// with a priority-resolved registered RGB pixel and overlap flag.
module sprite_field #(
    parameter int              N        = 3,
    parameter int              SCREEN_W = 640,
    parameter int              SCREEN_H = 480,
    parameter int              STEP     = 1,
    parameter logic [N*10-1:0] HALF     = {10'd40, 10'd80, 10'd60},
    parameter logic [N*3-1:0]  COLOUR   = {3'b010, 3'b001, 3'b100},
    parameter logic [N*10-1:0] INIT_X   = {10'd300, 10'd400, 10'd160},
    parameter logic [N*10-1:0] INIT_Y   = {10'd320, 10'd240, 10'd120},
    parameter logic [N*2-1:0]  INIT_DIR = {2'b10, 2'b01, 2'b11}
) (
    input logic           clk,
    input logic           rst,
    sprite_field_if.slave bus
);
    typedef enum logic {IDLE, UPDATE} state_t;

    state_t     state;
    logic [2:0] idx;
    logic       pending;
    logic [9:0] cx [N];
    logic [9:0] cy [N];
    logic       xdir [N];
    logic       ydir [N];

    logic ld_go, anim_go;

    // Returns {new_dir, new_centre} for one axis; all arithmetic is 11-bit.
    function automatic logic [10:0] step_axis(input logic [9:0] c, input logic dir,
                                              input logic [9:0] h, input logic [10:0] lim);
        logic [10:0] c11, h11, cand;
        c11  = {1'b0, c};
        h11  = {1'b0, h};
        cand = c11 + 11'(STEP);
        if (dir) begin
            if (cand + h11 >= lim) step_axis = {1'b0, 10'(lim - 11'd1 - h11)};
            else                   step_axis = {1'b1, cand[9:0]};
        end else begin
            if (c11 < h11 + 11'(STEP)) step_axis = {1'b1, h};
            else                       step_axis = {1'b0, 10'(c11 - 11'(STEP))};
        end
    endfunction

    function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] c_x, input logic [9:0] c_y,
                                    input logic [9:0] h);
        logic signed [10:0] sx, sy, scx, scy, sh;
        sx  = $signed({1'b0, px});
        sy  = $signed({1'b0, py});
        scx = $signed({1'b0, c_x});
        scy = $signed({1'b0, c_y});
        sh  = $signed({1'b0, h});
        in_box = (sx > scx - sh) && (sx < scx + sh) && (sy > scy - sh) && (sy < scy + sh);
    endfunction

    assign bus.ld_ready  = (state == IDLE);
    assign bus.busy      = (state == UPDATE);
    assign bus.dbg_state = (state == UPDATE);
    assign ld_go         = bus.ld_valid && (state == IDLE);
    assign anim_go       = bus.animate && !bus.pause;

    // A load takes priority over a frame pulse; that pulse is remembered in pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cx[i]   <= INIT_X[10*i +: 10];
                cy[i]   <= INIT_Y[10*i +: 10];
                xdir[i] <= INIT_DIR[2*i+1];
                ydir[i] <= INIT_DIR[2*i];
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ld_go) begin
                        for (int i = 0; i < N; i++) begin
                            if (bus.ld_idx == 3'(i)) begin
                                cx[i] <= bus.ld_x;
                                cy[i] <= bus.ld_y;
                            end
                        end
                        if (anim_go) pending <= 1'b1;
                    end else if (anim_go || pending) begin
                        state   <= UPDATE;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == 3'(i)) begin
                            {xdir[i], cx[i]} <= step_axis(cx[i], xdir[i], HALF[10*i +: 10], 11'(SCREEN_W));
                            {ydir[i], cy[i]} <= step_axis(cy[i], ydir[i], HALF[10*i +: 10], 11'(SCREEN_H));
                        end
                    end
                    if (anim_go) pending <= 1'b1;
                    if (idx == 3'(N-1)) state <= IDLE;
                    else                idx   <= idx + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [N-1:0] in_s;
    logic [2:0]   col;
    logic [3:0]   cnt;

    always_comb begin
        in_s = '0;
        col  = '0;
        cnt  = '0;
        for (int i = 0; i < N; i++) begin
            in_s[i] = in_box(bus.x, bus.y, cx[i], cy[i], HALF[10*i +: 10]);
            cnt     = cnt + {3'b000, in_s[i]};
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (in_s[i]) col = COLOUR[3*i +: 3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.r   <= 1'b0;
            bus.g   <= 1'b0;
            bus.b   <= 1'b0;
            bus.hit <= 1'b0;
        end else if (bus.pixclk) begin
            {bus.r, bus.g, bus.b} <= bus.valid ? col : 3'b000;
            bus.hit               <= bus.valid && (cnt >= 4'd2);
        end
    end

    always_comb begin
        bus.dbg_cx = '0;
        bus.dbg_cy = '0;
        for (int i = 0; i < N; i++) begin
            bus.dbg_cx[10*i +: 10] = cx[i];
            bus.dbg_cy[10*i +: 10] = cy[i];
        end
    end
endmodule

// File: tb/tb_sprite_field.sv
// Directed bench for sprite_field: frame updates, bounces, load handshake, pixel priority, reset.
module tb_sprite_field;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;
  logic [6:0] seq;

  sprite_field_if #(.N(3)) bus();

  sprite_field dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cx_of(input int i);
    return bus.dbg_cx[10*i +: 10];
  endfunction

  function automatic logic [9:0] cy_of(input int i);
    return bus.dbg_cy[10*i +: 10];
  endfunction

  task automatic chk_pos(input string tag, input int i, input int ex, input int ey);
    chk({tag, "_x"}, 32'(cx_of(i)), 32'(ex));
    chk({tag, "_y"}, 32'(cy_of(i)), 32'(ey));
  endtask

  task automatic chk_pix(input string tag, input logic [2:0] ergb, input logic ehit);
    chk({tag, "_rgb"}, 32'({bus.r, bus.g, bus.b}), 32'(ergb));
    chk({tag, "_hit"}, 32'(bus.hit), 32'(ehit));
  endtask

  // Waits for IDLE with a cycle budget; returns the number of busy samples seen.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 20) begin
      cycles++;
      tick();
    end
    if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_animate();
    int c;
    bus.animate = 1'b1;
    tick();
    bus.animate = 1'b0;
    wait_idle(c);
  endtask

  // Holds a load request until accepted; returns cycles spent held off.
  task automatic do_load(input logic [2:0] i, input logic [9:0] lx, input logic [9:0] ly,
                         output int held);
    logic acc;
    held = 0;
    bus.ld_valid = 1'b1;
    bus.ld_idx   = i;
    bus.ld_x     = lx;
    bus.ld_y     = ly;
    acc = 1'b0;
    while (!acc && held < 20) begin
      acc = bus.ld_ready;
      if (!acc) held++;
      tick();
    end
    bus.ld_valid = 1'b0;
    if (!acc) chk("load_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pixclk = 1'b0; bus.animate = 1'b0; bus.pause = 1'b0;
    bus.x = '0; bus.y = '0; bus.valid = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_idx = '0; bus.ld_x = '0; bus.ld_y = '0;
    tick();
    tick();

    // reset state
    chk_pix("rst", 3'b000, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    chk_pos("rst_s0", 0, 160, 120);
    chk_pos("rst_s1", 1, 400, 240);
    chk_pos("rst_s2", 2, 300, 320);
    rst = 1'b0;
    tick();

    // one frame with defaults; busy for exactly N cycles
    bus.animate = 1'b1;
    tick();
    bus.animate = 1'b0;
    chk("upd_state", 32'(bus.dbg_state), 32'd1);
    chk("upd_ready", 32'(bus.ld_ready), 32'd0);
    wait_idle(n);
    chk("busy_len", 32'(n), 32'd3);
    chk_pos("f1_s0", 0, 161, 121);
    chk_pos("f1_s1", 1, 399, 241);
    chk_pos("f1_s2", 2, 301, 319);

    // right-edge bounce
    do_load(3'd0, 10'd578, 10'd120, n);
    chk_pos("ld_s0", 0, 578, 120);
    do_animate();
    chk_pos("rb1", 0, 579, 121);
    do_animate();
    chk_pos("rb2", 0, 579, 122);
    do_animate();
    chk_pos("rb3", 0, 578, 123);
    chk_pos("rb3_s2", 2, 304, 316);

    // pixel priority and boundaries
    do_load(3'd0, 10'd160, 10'd120, n);
    do_load(3'd1, 10'd160, 10'd120, n);
    bus.x = 10'd160; bus.y = 10'd120; bus.valid = 1'b1; bus.pixclk = 1'b1;
    tick();
    chk_pix("pix_both", 3'b100, 1'b1);
    bus.x = 10'd100;
    tick();
    chk_pix("pix_edge", 3'b001, 1'b0);
    bus.pixclk = 1'b0; bus.x = 10'd160;
    tick();
    chk_pix("pix_hold", 3'b001, 1'b0);
    bus.pixclk = 1'b1; bus.x = 10'd300; bus.y = 10'd316;
    tick();
    chk_pix("pix_s2", 3'b010, 1'b0);
    bus.x = 10'd160; bus.y = 10'd120; bus.valid = 1'b0;
    tick();
    chk_pix("pix_blank", 3'b000, 1'b0);

    // pause discards animate
    bus.pause = 1'b1; bus.animate = 1'b1;
    tick();
    bus.animate = 1'b0;
    chk("pause_busy", 32'(bus.busy), 32'd0);
    tick();
    chk_pos("pause_s0", 0, 160, 120);
    bus.pause = 1'b0;

    // animate during UPDATE becomes pending
    bus.animate = 1'b1;
    tick();
    tick();
    bus.animate = 1'b0;
    seq = '0;
    for (int i = 0; i < 7; i++) begin
      seq = {seq[5:0], bus.busy};
      tick();
    end
    chk("pend_busy_seq", 32'(seq), 32'(7'b1101110));
    chk_pos("pend_s0", 0, 158, 122);

    // load held off during UPDATE
    bus.animate = 1'b1;
    tick();
    bus.animate = 1'b0;
    do_load(3'd2, 10'd500, 10'd400, n);
    chk("held_cycles", 32'(n), 32'd3);
    chk_pos("held_s2", 2, 500, 400);
    chk_pos("held_s0", 0, 157, 123);

    // out-of-range index ignored
    do_load(3'd7, 10'd1, 10'd1, n);
    chk_pos("idx7_s0", 0, 157, 123);
    chk_pos("idx7_s1", 1, 157, 123);
    chk_pos("idx7_s2", 2, 500, 400);

    // load and animate together: load wins, animate deferred
    bus.ld_valid = 1'b1; bus.ld_idx = 3'd0; bus.ld_x = 10'd200; bus.ld_y = 10'd200;
    bus.animate = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.animate = 1'b0;
    chk("coll_busy0", 32'(bus.busy), 32'd0);
    chk_pos("coll_ld", 0, 200, 200);
    tick();
    chk("coll_busy1", 32'(bus.busy), 32'd1);
    wait_idle(n);
    chk_pos("coll_upd", 0, 199, 201);

    // left-edge bounce
    do_load(3'd0, 10'd61, 10'd300, n);
    do_animate();
    chk_pos("lb1", 0, 60, 301);
    do_animate();
    chk_pos("lb2", 0, 60, 302);
    do_animate();
    chk_pos("lb3", 0, 61, 303);

    // asynchronous reset in the second UPDATE cycle
    bus.x = 10'd61; bus.y = 10'd303; bus.valid = 1'b1; bus.pixclk = 1'b1;
    tick();
    chk("pre_rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'(3'b100));
    bus.animate = 1'b1;
    tick();
    bus.animate = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_pix("arst", 3'b000, 1'b0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.ld_ready), 32'd1);
    chk_pos("arst_s0", 0, 160, 120);
    chk_pos("arst_s1", 1, 400, 240);
    chk_pos("arst_s2", 2, 300, 320);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
